// File: rtl/pmu_ahb_pkg.sv
// Shared definitions for the PMU AHB initiator.
// Contents:
//   - AHB encodings for htrans, hresp, hsize, hburst and hprot
//   - state_e : initiator FSM state encoding
//   - in_range: address window decode against a base/mask pair
package pmu_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_ERR
  } state_e;

  // An address is inside the window when every bit outside the mask
  // matches the base.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & ~mask) == (base & ~mask);
  endfunction

endpackage

// File: rtl/pmu_ahb_master.sv
// Single-outstanding AHB initiator for the PMU register bank.
// Each accepted request becomes one single-word AHB transfer; the result is
// returned on a one-cycle response strobe. Out-of-window requests never
// reach the bus and are answered with an error.
// Ports:
//   clk_i, rstn_i                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o            request handshake
//   req_write_i/req_addr_i/req_wdata_i request payload
//   rsp_valid_o/rsp_rdata_o/rsp_err_o  one-cycle response
//   hsel_o..hwdata_o                   AHB address/data phase outputs
//   hreadyi_i/hresp_i/hrdata_i         AHB slave response inputs
module pmu_ahb_master
  import pmu_ahb_pkg::*;
#(
  parameter logic [31:0] HADDR      = 32'h80100000,
  parameter logic [31:0] HMASK      = 32'hfff,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  hsel_o,
  output logic [DATA_WIDTH-1:0] haddr_o,
  output logic                  hwrite_o,
  output logic [1:0]            htrans_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic                  hmastlock_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic                  hreadyi_i,
  input  logic [1:0]            hresp_i,
  input  logic [DATA_WIDTH-1:0] hrdata_i
);

  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  addr_ok;

  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  hsel_q;
  logic [DATA_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  logic [1:0]            htrans_q;
  logic [DATA_WIDTH-1:0] hwdata_q;

  // req_ready_q is only ever high in IDLE or RESP, so an accept always
  // originates from one of those two states.
  assign accept  = req_valid_i & req_ready_q;
  assign addr_ok = in_range(req_addr_i, HADDR, HMASK);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = '0;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = addr_ok ? ST_ADDR : ST_ERR;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (hreadyi_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Sticky so the first cycle of a two-cycle ERROR is not lost.
        if (hresp_i != HRESP_OKAY) err_d = 1'b1;
        if (hreadyi_i) begin
          state_d = ST_RESP;
          rdata_d = (write_q || err_d) ? '0 : hrdata_i;
        end
      end
      ST_ERR: begin
        err_d   = 1'b1;
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is registered from the next state so it changes on the
  // same edge the FSM enters the corresponding phase.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == ST_IDLE) || (state_d == ST_RESP);
      hsel_q      <= (state_d == ST_ADDR);
      htrans_q    <= (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      rsp_valid_q <= (state_d == ST_RESP);
      rsp_err_q   <= (state_d == ST_RESP) ? err_d : 1'b0;
      rsp_rdata_q <= (state_d == ST_RESP) ? rdata_d : '0;
      if (accept) begin
        write_q <= req_write_i;
        wdata_q <= req_wdata_i;
        // Out-of-window requests leave the bus address untouched.
        if (addr_ok) begin
          haddr_q  <= req_addr_i;
          hwrite_q <= req_write_i;
        end
      end
      if ((state_q == ST_ADDR) && (state_d == ST_DATA)) begin
        hwdata_q <= write_q ? wdata_q : '0;
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign hsel_o      = hsel_q;
  assign haddr_o     = haddr_q;
  assign hwrite_o    = hwrite_q;
  assign htrans_o    = htrans_q;
  assign hwdata_o    = hwdata_q;
  assign hsize_o     = HSIZE_WORD;
  assign hburst_o    = HBURST_SINGLE;
  assign hprot_o     = HPROT_DEFAULT;
  assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_pmu_ahb_master.sv
module tb_pmu_ahb_master;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        hsel_o;
  logic [31:0] haddr_o;
  logic        hwrite_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic        hmastlock_o;
  logic [31:0] hwdata_o;
  logic        hreadyi;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  int n_chk  = 0;
  int n_fail = 0;

  pmu_ahb_master dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .hsel_o      (hsel_o),
    .haddr_o     (haddr_o),
    .hwrite_o    (hwrite_o),
    .htrans_o    (htrans_o),
    .hsize_o     (hsize_o),
    .hburst_o    (hburst_o),
    .hprot_o     (hprot_o),
    .hmastlock_o (hmastlock_o),
    .hwdata_o    (hwdata_o),
    .hreadyi_i   (hreadyi),
    .hresp_i     (hresp),
    .hrdata_i    (hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: window is the 4 KiB block starting at 0x80100000.
  function automatic bit model_in_window(input logic [31:0] a);
    return (a >= 32'h80100000) && (a <= 32'h80100fff);
  endfunction

  function automatic int model_latency(input logic [31:0] a, input int aw, input int dw, input bit berr);
    if (!model_in_window(a)) return 2;
    return 3 + aw + (berr ? 1 : dw);
  endfunction

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    bit          berr;
    logic [31:0] rd;
    bit          e_err;
    logic [31:0] e_rdata;
    int          e_lat;
  } vec_t;

  // One request with a scripted slave. aw/dw are wait cycles in the
  // address/data phase; berr makes the slave give a two-cycle ERROR.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int aw, input int dw, input bit berr,
                         input logic [31:0] rd, input bit e_err, input logic [31:0] e_rdata,
                         input int e_lat);
    int   wk;
    int   phase;
    int   nxt;
    int   aw_left;
    int   dw_left;
    bit   err_step;
    int   lat;
    int   n_rsp;
    int   n_nonseq;
    int   n_hsel;
    logic        got_err;
    logic [31:0] got_rdata;
    wk = 0;
    while (req_ready_o !== 1'b1 && wk < 20) begin
      @(negedge clk);
      wk++;
    end
    chk({tag, ".ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    hreadyi   = 1'b1;
    hresp     = 2'b00;
    @(posedge clk);
    phase = 0; aw_left = aw; dw_left = dw; err_step = 1'b0;
    lat = -1; n_rsp = 0; n_nonseq = 0; n_hsel = 0;
    got_err = 1'b0; got_rdata = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = ~wr;
      end
      if (htrans_o == 2'b10) n_nonseq++;
      if (hsel_o) n_hsel++;
      if (rsp_valid_o) begin
        n_rsp++;
        if (lat < 0) begin
          lat       = k;
          got_err   = rsp_err_o;
          got_rdata = rsp_rdata_o;
        end
      end
      if (phase == 0 && htrans_o == 2'b10) phase = 1;
      nxt     = phase;
      hreadyi = 1'b1;
      hresp   = 2'b00;
      hrdata  = $urandom;
      if (phase == 1) begin
        chk({tag, ".haddr"}, haddr_o, addr);
        chk({tag, ".hwrite"}, {31'd0, hwrite_o}, {31'd0, wr});
        chk({tag, ".hsel_a"}, {31'd0, hsel_o}, 32'd1);
        chk({tag, ".ctrl"}, {20'd0, hsize_o, hburst_o, hprot_o, 1'b0, hmastlock_o, 1'b0},
            {20'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0, 1'b0});
        if (aw_left > 0) begin
          hreadyi = 1'b0;
          aw_left--;
        end else begin
          nxt = 2;
        end
      end else if (phase == 2) begin
        chk({tag, ".htrans_d"}, {30'd0, htrans_o}, 32'd0);
        chk({tag, ".hsel_d"}, {31'd0, hsel_o}, 32'd0);
        if (wr) chk({tag, ".hwdata"}, hwdata_o, wdata);
        if (berr) begin
          hresp = 2'b01;
          if (!err_step) begin
            hreadyi  = 1'b0;
            err_step = 1'b1;
          end else begin
            hrdata = rd;
            nxt    = 3;
          end
        end else if (dw_left > 0) begin
          hreadyi = 1'b0;
          dw_left--;
        end else begin
          hrdata = rd;
          nxt    = 3;
        end
      end
      phase = nxt;
    end
    hreadyi = 1'b1;
    hresp   = 2'b00;
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".rsp_cnt"}, n_rsp, 32'd1);
    chk({tag, ".rsp_err"}, {31'd0, got_err}, {31'd0, e_err});
    chk({tag, ".rsp_rdata"}, got_rdata, e_rdata);
    chk({tag, ".nonseq_cnt"}, n_nonseq, (e_lat == 2) ? 0 : aw + 1);
    chk({tag, ".hsel_cnt"}, n_hsel, (e_lat == 2) ? 0 : aw + 1);
  endtask

  vec_t vt[8];

  initial begin
    int          nq[$];
    int          aq[$];
    int          rq[$];
    int          acc;
    bit          pend;
    int          n_bad_rsp;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          aw;
    int          dw;
    bit          be;
    bit          inw;

    vt[0] = '{1'b1, 32'h80100000, 32'h00000002, 0, 0, 1'b0, 32'h11111111, 1'b0, 32'h0, 3};
    vt[1] = '{1'b0, 32'h801000ac, 32'h0, 1, 2, 1'b0, 32'hcafecafe, 1'b0, 32'hcafecafe, 6};
    vt[2] = '{1'b1, 32'h801000b0, 32'h5a5a5a5a, 0, 0, 1'b1, 32'h22222222, 1'b1, 32'h0, 4};
    vt[3] = '{1'b0, 32'h80200000, 32'h0, 0, 0, 1'b0, 32'h33333333, 1'b1, 32'h0, 2};
    vt[4] = '{1'b0, 32'h80100ffc, 32'h0, 0, 0, 1'b0, 32'h12345678, 1'b0, 32'h12345678, 3};
    vt[5] = '{1'b0, 32'h80101000, 32'h0, 0, 0, 1'b0, 32'h44444444, 1'b1, 32'h0, 2};
    vt[6] = '{1'b1, 32'h800ffffc, 32'h77777777, 0, 0, 1'b0, 32'h0, 1'b1, 32'h0, 2};
    vt[7] = '{1'b0, 32'h80100040, 32'h0, 2, 0, 1'b1, 32'hdeadbeef, 1'b1, 32'h0, 6};

    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    hreadyi = 1'b1; hresp = 2'b00; hrdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.htrans", {30'd0, htrans_o}, 32'd0);
    chk("rst.hsel", {31'd0, hsel_o}, 32'd0);
    chk("rst.haddr", haddr_o, 32'd0);
    chk("rst.hwdata", hwdata_o, 32'd0);
    chk("rst.rsp", {29'd0, hwrite_o, rsp_valid_o, rsp_err_o}, 32'd0);
    chk("rst.rdata", rsp_rdata_o, 32'd0);
    chk("rst.ready", {31'd0, req_ready_o}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rst.ready_rel", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    chk("rst.ready_edge", {31'd0, req_ready_o}, 32'd1);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].aw, vt[i].dw,
              vt[i].berr, vt[i].rd, vt[i].e_err, vt[i].e_rdata, vt[i].e_lat);
    end

    // Back-to-back: valid held high for three in-window writes
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80100010; req_wdata = 32'ha0;
    acc = 0; pend = 1'b0; n_bad_rsp = 0;
    for (int c = 1; c <= 20; c++) begin
      if (pend) begin
        pend = 1'b0;
        if (acc == 3) req_valid = 1'b0;
        else begin
          req_addr  = req_addr + 32'h4;
          req_wdata = req_wdata + 32'h1;
        end
      end
      if (htrans_o == 2'b10) nq.push_back(c);
      if (rsp_valid_o) begin
        rq.push_back(c);
        if (rsp_err_o !== 1'b0) n_bad_rsp++;
      end
      if (req_valid && req_ready_o) begin
        aq.push_back(c);
        acc++;
        pend = 1'b1;
      end
      @(negedge clk);
    end
    chk("b2b.accepts", aq.size(), 32'd3);
    chk("b2b.rsps", rq.size(), 32'd3);
    chk("b2b.rsp_err", n_bad_rsp, 32'd0);
    chk("b2b.nonseq_cnt", nq.size(), 32'd3);
    if (nq.size() == 3) begin
      chk("b2b.gap1", nq[1] - nq[0], 32'd3);
      chk("b2b.gap2", nq[2] - nq[1], 32'd3);
    end
    if (aq.size() == 3 && rq.size() == 3) begin
      chk("b2b.acc2_rsp", aq[1], rq[0]);
      chk("b2b.acc3_rsp", aq[2], rq[1]);
    end

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom_range(0, 1));
      inw = ($urandom_range(0, 3) != 0);
      a   = inw ? (32'h80100000 + ($urandom & 32'hffc)) : ($urandom & 32'hfffffffc);
      wd  = $urandom;
      rd  = $urandom;
      aw  = $urandom_range(0, 2);
      dw  = $urandom_range(0, 2);
      be  = ($urandom_range(0, 4) == 0);
      run_txn($sformatf("rnd%0d", i), wr, a, wd, aw, dw, be, rd,
              !model_in_window(a) || be,
              (!model_in_window(a) || be || wr) ? 32'h0 : rd,
              model_latency(a, aw, dw, be));
    end

    // Reset during a stalled data phase
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80100020; hreadyi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst.addr_phase", {30'd0, htrans_o}, 32'd2);
    @(negedge clk);
    hreadyi = 1'b0;
    chk("mrst.data_phase", {30'd0, htrans_o}, 32'd0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst.htrans", {30'd0, htrans_o}, 32'd0);
    chk("mrst.hsel", {31'd0, hsel_o}, 32'd0);
    chk("mrst.haddr", haddr_o, 32'd0);
    chk("mrst.rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("mrst.ready", {31'd0, req_ready_o}, 32'd0);
    n_bad_rsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid_o) n_bad_rsp++;
    end
    rstn = 1'b1;
    hreadyi = 1'b1;
    #1;
    chk("mrst.ready_rel", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    chk("mrst.ready_edge", {31'd0, req_ready_o}, 32'd1);
    repeat (5) begin
      if (rsp_valid_o) n_bad_rsp++;
      @(negedge clk);
    end
    chk("mrst.no_rsp", n_bad_rsp, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
